// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback arbiter.
//   AW_DEF / DW_DEF : default register address / data widths
//   REG_ZERO        : hard-wired zero register (writes dropped, never busy)
//   MAX_REQ         : widest requester vector the round-robin helper handles
//   rr_pick()       : first set request at or after the pointer, with wrap
package regbank_wb_arbiter_pkg;

  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned MAX_REQ  = 4;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } rr_pick_t;

  // Scan req starting at ptr, rising and wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [1:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t    pick;
    int unsigned i;
    pick = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      i = (32'(ptr) + k) % n;
      if (k < n && !pick.hit && req[i[1:0]]) begin
        pick.hit = 1'b1;
        pick.idx = i[1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/regbank_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter for a shared single-ported resource.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : NREQ request vector (one bit per requester)
//   grant      : one-hot grant, combinational from req; all-zero in reset
// Every grant is a transfer; the pointer moves to winner+1 after a grant
// and holds otherwise.
module rr_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  logic [1:0]         ptr_q;
  logic [1:0]         ptr_d;
  logic [MAX_REQ-1:0] req_pad;
  rr_pick_t           pick;

  always_comb begin
    req_pad             = '0;
    req_pad[NREQ-1:0]   = req;
    pick                = rr_pick(req_pad, ptr_q, NREQ);
    grant               = '0;
    ptr_d               = ptr_q;
    if (pick.hit && rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pick.idx == 2'(i)) grant[i] = 1'b1;
      end
      ptr_d = (pick.idx == 2'(NREQ - 1)) ? '0 : pick.idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-port controller for the register bank.
//   req_valid/req_ready/req_addr/req_data : NREQ writeback requesters,
//                                           round-robin arbitrated
//   claim_valid/claim_addr                : issue stage reserves a destination
//   q_addr1/q_addr2 -> q_busy1/q_busy2    : read-hazard queries
//   RegEn/WriteRegister/WriteData         : bank write port, registered
//   err_unclaimed                         : sticky, write to a non-busy reg
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               claim_valid,
  input  logic [AW-1:0]      claim_addr,
  input  logic [AW-1:0]      q_addr1,
  input  logic [AW-1:0]      q_addr2,
  output logic               q_busy1,
  output logic               q_busy2,
  output logic               RegEn,
  output logic [AW-1:0]      WriteRegister,
  output logic [DW-1:0]      WriteData,
  output logic               err_unclaimed
);

  localparam int unsigned NREGS = 1 << AW;

  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  logic             wr_en_q,   wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [NREGS-1:0] busy_q,    busy_d;
  logic             err_q,     err_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    // Transfers to the zero register are accepted but never reach the bank.
    wr_en_d   = xfer && (sel_addr != AW'(REG_ZERO));
    wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data : wr_data_q;

    // Clear first, then set: a new claim supersedes a committing producer.
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (claim_valid && claim_addr != AW'(REG_ZERO)) busy_d[claim_addr] = 1'b1;

    err_d = err_q | (wr_en_q & ~busy_q[wr_addr_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign RegEn         = wr_en_q;
  assign WriteRegister = wr_addr_q;
  assign WriteData     = wr_data_q;
  assign err_unclaimed = err_q;

  // A write committing this cycle is already visible in the bank.
  assign q_busy1 = busy_q[q_addr1] & ~(wr_en_q && wr_addr_q == q_addr1);
  assign q_busy2 = busy_q[q_addr2] & ~(wr_en_q && wr_addr_q == q_addr2);

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
module tb_regbank_wb_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_busy1, q_busy2;
  logic        RegEn;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        err_unclaimed;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  wr_t         exp_q[$];

  regbank_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      ({addr1, addr0}),
    .req_data      ({data1, data0}),
    .claim_valid   (claim_valid),
    .claim_addr    (claim_addr),
    .q_addr1       (q_addr1),
    .q_addr2       (q_addr2),
    .q_busy1       (q_busy1),
    .q_busy2       (q_busy2),
    .RegEn         (RegEn),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .err_unclaimed (err_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge: check grant, then the write the scoreboard
  // expects this cycle, then queue the write expected from this cycle's grant.
  task automatic tick(input string tag, input logic [1:0] exp_rdy,
                      input logic push_en, input logic [4:0] paddr, input logic [31:0] pdata);
    wr_t e;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".RegEn"}, 32'(RegEn), 32'(e.en));
      if (e.en) begin
        chk({tag, ".WriteRegister"}, 32'(WriteRegister), 32'(e.addr));
        chk({tag, ".WriteData"}, WriteData, e.data);
      end
    end
    exp_q.push_back({push_en, paddr, pdata});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; claim_valid = 1'b0; claim_addr = '0;
    addr0 = 5'd3; addr1 = 5'd4; data0 = '0; data1 = '0; q_addr1 = 5'd5; q_addr2 = 5'd7;
    #3;
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.RegEn", 32'(RegEn), 0);
    adv();
    rst_n = 1'b1; req_valid = 2'b00;
    exp_q.push_back('0);

    // 1: idle after reset
    tick("idle", 2'b00, 0, 0, 0);
    chk("idle.q_busy1", 32'(q_busy1), 0);
    chk("idle.q_busy2", 32'(q_busy2), 0);
    chk("idle.err", 32'(err_unclaimed), 0);
    adv();

    // 2: claim r5, then req0 writes r5
    claim_valid = 1'b1; claim_addr = 5'd5;
    tick("claim5", 2'b00, 0, 0, 0); adv();
    claim_valid = 1'b0; req_valid = 2'b01; addr0 = 5'd5; data0 = 32'hDEADBEEF;
    tick("wr5", 2'b01, 1, 5'd5, 32'hDEADBEEF);
    chk("wr5.q_busy1_pending", 32'(q_busy1), 1);
    adv();
    req_valid = 2'b00;
    tick("commit5", 2'b00, 0, 0, 0);
    chk("commit5.q_busy1", 32'(q_busy1), 0);
    adv();
    tick("after5", 2'b00, 0, 0, 0);
    chk("after5.hold_addr", 32'(WriteRegister), 5);
    chk("after5.q_busy1", 32'(q_busy1), 0);
    adv();

    // 4: req1 writes r0 (pointer is 1 here, so it wins; pointer returns to 0)
    req_valid = 2'b10; addr1 = 5'd0; data1 = 32'h1234;
    tick("wr0", 2'b10, 0, 0, 0); adv();
    req_valid = 2'b00;
    tick("after0", 2'b00, 0, 0, 0);
    chk("after0.err", 32'(err_unclaimed), 0);
    chk("after0.hold_addr", 32'(WriteRegister), 5);
    adv();

    // 3: both requesters busy for 4 grants, pointer starts at 0
    claim_valid = 1'b1; claim_addr = 5'd1;
    tick("pre1", 2'b00, 0, 0, 0); adv();
    claim_addr = 5'd2;
    tick("pre2", 2'b00, 0, 0, 0); adv();
    claim_valid = 1'b0; req_valid = 2'b11;
    addr0 = 5'd1; data0 = 32'hA1A1_0001; addr1 = 5'd2; data1 = 32'hB2B2_0002;
    tick("rr0", 2'b01, 1, 5'd1, 32'hA1A1_0001); adv();
    claim_valid = 1'b1; claim_addr = 5'd1;
    tick("rr1", 2'b10, 1, 5'd2, 32'hB2B2_0002); adv();
    claim_addr = 5'd2;
    tick("rr2", 2'b01, 1, 5'd1, 32'hA1A1_0001); adv();
    claim_valid = 1'b0;
    tick("rr3", 2'b10, 1, 5'd2, 32'hB2B2_0002); adv();
    req_valid = 2'b00;
    tick("rr4", 2'b00, 0, 0, 0); adv();
    q_addr1 = 5'd1; q_addr2 = 5'd2;
    tick("rr5", 2'b00, 0, 0, 0);
    chk("rr5.err", 32'(err_unclaimed), 0);
    chk("rr5.q_busy1", 32'(q_busy1), 0);
    chk("rr5.q_busy2", 32'(q_busy2), 0);
    adv();

    // 5: re-claim r7 in the same cycle its pending write commits
    q_addr2 = 5'd7;
    claim_valid = 1'b1; claim_addr = 5'd7;
    tick("claim7", 2'b00, 0, 0, 0); adv();
    claim_valid = 1'b0; req_valid = 2'b01; addr0 = 5'd7; data0 = 32'h0000_0077;
    tick("wr7", 2'b01, 1, 5'd7, 32'h0000_0077); adv();
    req_valid = 2'b00; claim_valid = 1'b1; claim_addr = 5'd7;
    tick("commit7", 2'b00, 0, 0, 0);
    chk("commit7.q_busy2", 32'(q_busy2), 0);
    adv();
    claim_valid = 1'b0;
    tick("after7", 2'b00, 0, 0, 0);
    chk("after7.q_busy2", 32'(q_busy2), 1);
    chk("after7.err", 32'(err_unclaimed), 0);
    adv();

    // 6: unclaimed write to r9 (pointer is 1 after req0 won)
    req_valid = 2'b10; addr1 = 5'd9; data1 = 32'h0000_0099;
    tick("wr9", 2'b10, 1, 5'd9, 32'h0000_0099); adv();
    req_valid = 2'b00;
    tick("commit9", 2'b00, 0, 0, 0);
    chk("commit9.err", 32'(err_unclaimed), 0);
    adv();
    tick("after9", 2'b00, 0, 0, 0);
    chk("after9.err", 32'(err_unclaimed), 1);
    adv();

    // 6: asynchronous reset in the middle of a burst
    claim_valid = 1'b1; claim_addr = 5'd3;
    tick("claim3", 2'b00, 0, 0, 0); adv();
    claim_valid = 1'b0; req_valid = 2'b11;
    addr0 = 5'd3; data0 = 32'h3333_3333; addr1 = 5'd4; data1 = 32'h4444_4444;
    tick("burst0", 2'b01, 1, 5'd3, 32'h3333_3333); adv();
    tick("burst1", 2'b10, 1, 5'd4, 32'h4444_4444);
    chk("burst1.q_busy2", 32'(q_busy2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.RegEn", 32'(RegEn), 0);
    chk("arst.err", 32'(err_unclaimed), 0);
    chk("arst.q_busy2", 32'(q_busy2), 0);
    chk("arst.req_ready", 32'(req_ready), 0);
    exp_q.delete();
    exp_q.push_back('0);
    adv();
    rst_n = 1'b1; req_valid = 2'b00;
    tick("post_rst", 2'b00, 0, 0, 0);
    chk("post_rst.err", 32'(err_unclaimed), 0);
    chk("post_rst.q_busy2", 32'(q_busy2), 0);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
